// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: postfix (RPN) token sequencer and sole master of an external
// WIDTH-bit stack. Operands are pushed, binary operators pop b then a and push
// the result, RESULT pops the top entry onto the result port. The controller
// tracks occupancy so that overflow/underflow never reaches the stack.
// Every output is a register loaded from the next-state decode, so a strobe
// is visible during the cycle in which the FSM sits in the matching state.
module rpn_stack_ctrl #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 8,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             tok_valid_i,
    output logic             tok_ready_o,
    input  logic             tok_is_op_i,
    input  logic [WIDTH-1:0] tok_data_i,
    output logic             stk_push_o,
    output logic             stk_pop_o,
    output logic [WIDTH-1:0] stk_value_in_o,
    input  logic [WIDTH-1:0] stk_value_out_i,
    output logic             res_valid_o,
    output logic [WIDTH-1:0] res_data_o,
    output logic [DW-1:0]    depth_o,
    output logic [2:0]       err_o
);

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_AND    = 3'd2;
    localparam logic [2:0] OP_OR     = 3'd3;
    localparam logic [2:0] OP_XOR    = 3'd4;
    localparam logic [2:0] OP_RESULT = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PUSH_V = 3'd1,
        S_POP_B  = 3'd2,
        S_CAP_B  = 3'd3,
        S_POP_A  = 3'd4,
        S_CAP_A  = 3'd5,
        S_PUSH_R = 3'd6,
        S_EMIT   = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] value_in_q, value_in_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_valid_q, res_valid_d;
    logic             push_q, push_d;
    logic             pop_q, pop_d;
    logic             ready_q, ready_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [2:0]       err_q, err_d;
    logic             accept_s;

    // Binary operator datapath; a is the deeper entry, b the former top.
    function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    assign accept_s = tok_valid_i & ready_q;

    // Next-state, depth/error bookkeeping and registered-output decode.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        b_d         = b_q;
        value_in_d  = value_in_q;
        res_data_d  = res_data_q;
        res_valid_d = 1'b0;
        depth_d     = depth_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    if (!tok_is_op_i) begin
                        if (depth_q < DW'(DEPTH)) begin
                            state_d    = S_PUSH_V;
                            value_in_d = tok_data_i;
                            depth_d    = depth_q + DW'(1);
                        end else begin
                            err_d[1] = 1'b1;
                        end
                    end else if (tok_data_i[2:0] > OP_RESULT) begin
                        err_d[2] = 1'b1;
                    end else if ((tok_data_i[2:0] == OP_RESULT) ? (depth_q >= DW'(1))
                                                                : (depth_q >= DW'(2))) begin
                        state_d = S_POP_B;
                        op_d    = tok_data_i[2:0];
                        depth_d = depth_q - DW'(1);
                    end else begin
                        err_d[0] = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PUSH_V: state_d = S_IDLE;
            S_POP_B:  state_d = S_CAP_B;
            S_CAP_B: begin
                b_d = stk_value_out_i;
                if (op_q == OP_RESULT) begin
                    state_d     = S_EMIT;
                    res_data_d  = stk_value_out_i;
                    res_valid_d = 1'b1;
                end else begin
                    state_d = S_POP_A;
                    depth_d = depth_q - DW'(1);
                end
            end
            S_POP_A:  state_d = S_CAP_A;
            S_CAP_A: begin
                state_d    = S_PUSH_R;
                value_in_d = alu(op_q, stk_value_out_i, b_q);
                depth_d    = depth_q + DW'(1);
            end
            S_PUSH_R: state_d = S_IDLE;
            S_EMIT:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        push_d  = (state_d == S_PUSH_V) || (state_d == S_PUSH_R);
        pop_d   = (state_d == S_POP_B) || (state_d == S_POP_A);
        ready_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            b_q         <= {WIDTH{1'b0}};
            value_in_q  <= {WIDTH{1'b0}};
            res_data_q  <= {WIDTH{1'b0}};
            res_valid_q <= 1'b0;
            push_q      <= 1'b0;
            pop_q       <= 1'b0;
            ready_q     <= 1'b0;
            depth_q     <= {DW{1'b0}};
            err_q       <= 3'b000;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            b_q         <= b_d;
            value_in_q  <= value_in_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
            push_q      <= push_d;
            pop_q       <= pop_d;
            ready_q     <= ready_d;
            depth_q     <= depth_d;
            err_q       <= err_d;
        end
    end

    assign tok_ready_o    = ready_q;
    assign stk_push_o     = push_q;
    assign stk_pop_o      = pop_q;
    assign stk_value_in_o = value_in_q;
    assign res_valid_o    = res_valid_q;
    assign res_data_o     = res_data_q;
    assign depth_o        = depth_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_rpn_stack_ctrl.sv
// Bench for rpn_stack_ctrl: a behavioural 8-entry stack answers the strobes,
// and a queue-based RPN evaluator predicts depth, error flags, results and
// strobe counts for directed and randomized token streams.
module tb_rpn_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tok_valid = 1'b0;
    logic        tok_ready;
    logic        tok_is_op = 1'b0;
    logic [15:0] tok_data = 16'h0000;
    logic        stk_push;
    logic        stk_pop;
    logic [15:0] stk_value_in;
    logic [15:0] stk_value_out;
    logic        res_valid;
    logic [15:0] res_data;
    logic [3:0]  depth;
    logic [2:0]  err;

    int checks = 0;
    int failures = 0;

    rpn_stack_ctrl #(.WIDTH(16), .DEPTH(8)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .tok_valid_i    (tok_valid),
        .tok_ready_o    (tok_ready),
        .tok_is_op_i    (tok_is_op),
        .tok_data_i     (tok_data),
        .stk_push_o     (stk_push),
        .stk_pop_o      (stk_pop),
        .stk_value_in_o (stk_value_in),
        .stk_value_out_i(stk_value_out),
        .res_valid_o    (res_valid),
        .res_data_o     (res_data),
        .depth_o        (depth),
        .err_o          (err)
    );

    always #5 clk = ~clk;

    // Behavioural stack: pop data appears the cycle after the pop strobe.
    logic [15:0] smem [0:7];
    int          sp = 0;
    always @(posedge clk) begin
        if (reset) begin
            sp            <= 0;
            stk_value_out <= 16'h0000;
        end else if (stk_push && sp < 8) begin
            smem[sp] <= stk_value_in;
            sp       <= sp + 1;
        end else if (stk_pop && sp > 0) begin
            stk_value_out <= smem[sp-1];
            sp            <= sp - 1;
        end
    end

    // Strobe monitors.
    int          push_cnt = 0, pop_cnt = 0, res_cnt = 0, overlap_cnt = 0;
    logic [15:0] last_push = 16'h0000;
    always @(posedge clk) begin
        if (stk_push) begin
            push_cnt  <= push_cnt + 1;
            last_push <= stk_value_in;
        end
        if (stk_pop) pop_cnt <= pop_cnt + 1;
        if (res_valid) res_cnt <= res_cnt + 1;
        if (stk_push && stk_pop) overlap_cnt <= overlap_cnt + 1;
    end

    // Reference RPN model.
    logic [15:0] mq[$];
    logic [2:0]  err_m = 3'b000;
    logic [15:0] res_m = 16'h0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        tok_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(tok_ready), 32'd0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_res", 32'(res_data), 32'd0);
        chk("rst_strobes", {29'd0, stk_push, stk_pop, res_valid}, 32'd0);
        reset = 1'b0;
        mq.delete();
        err_m = 3'b000;
        res_m = 16'h0000;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!tok_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(tok_ready), 32'd1);
    endtask

    task automatic send(input logic is_op, input logic [15:0] data);
        int exp_push = 0, exp_pop = 0, exp_res = 0;
        int p0, q0, r0;
        logic [15:0] a, b, r;
        r = 16'h0000;
        if (!is_op) begin
            if (mq.size() < 8) begin
                mq.push_back(data);
                exp_push = 1;
                r = data;
            end else err_m[1] = 1'b1;
        end else if (data[2:0] == 3'd5) begin
            if (mq.size() >= 1) begin
                res_m = mq.pop_back();
                exp_pop = 1;
                exp_res = 1;
            end else err_m[0] = 1'b1;
        end else if (data[2:0] > 3'd5) begin
            err_m[2] = 1'b1;
        end else if (mq.size() >= 2) begin
            b = mq.pop_back();
            a = mq.pop_back();
            case (data[2:0])
                3'd0:    r = a + b;
                3'd1:    r = a - b;
                3'd2:    r = a & b;
                3'd3:    r = a | b;
                default: r = a ^ b;
            endcase
            mq.push_back(r);
            exp_pop = 2;
            exp_push = 1;
        end else err_m[0] = 1'b1;

        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = is_op;
        tok_data  = data;
        wait_ready("ready_before");
        p0 = push_cnt; q0 = pop_cnt; r0 = res_cnt;
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        tok_is_op = ~is_op;
        tok_data  = 16'($urandom);
        @(negedge clk);
        wait_ready("ready_after");
        chk("depth", 32'(depth), 32'(mq.size()));
        chk("err", 32'(err), 32'(err_m));
        chk("res_data", 32'(res_data), 32'(res_m));
        chk("push_cnt", 32'(push_cnt - p0), 32'(exp_push));
        chk("pop_cnt", 32'(pop_cnt - q0), 32'(exp_pop));
        chk("res_pulses", 32'(res_cnt - r0), 32'(exp_res));
        if (exp_push == 1) chk("push_value", 32'(last_push), 32'(r));
    endtask

    initial begin
        int p0, low_cnt;
        logic [15:0] d;
        logic [2:0]  op;
        int sel;

        // 1: ADD then RESULT
        do_reset();
        send(1'b0, 16'h0013);
        send(1'b0, 16'h00A5);
        send(1'b1, 16'h0000);
        chk("t1_sum_pushed", 32'(last_push), 32'h00B8);
        send(1'b1, 16'h0005);
        chk("t1_result", 32'(res_data), 32'h00B8);

        // 2: SUB wraps modulo 2^16
        send(1'b0, 16'h0005);
        send(1'b0, 16'h0007);
        send(1'b1, 16'h0001);
        send(1'b1, 16'h0005);
        chk("t2_result", 32'(res_data), 32'h0000FFFE);
        chk("t2_err", 32'(err), 32'd0);

        // 3: nine operands with tok_valid held high
        do_reset();
        wait_ready("t3_ready");
        tok_valid = 1'b1;
        tok_is_op = 1'b0;
        tok_data  = 16'h0100;
        p0 = push_cnt;
        low_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!tok_ready) low_cnt++;
        end
        tok_valid = 1'b0;
        @(negedge clk);
        chk("t3_pushes", 32'(push_cnt - p0), 32'd8);
        chk("t3_ready_low", 32'(low_cnt), 32'd8);
        chk("t3_err", 32'(err), 32'b010);
        chk("t3_depth", 32'(depth), 32'd8);

        // 4: underflow then RESULT
        do_reset();
        send(1'b0, 16'h0014);
        send(1'b1, 16'h0000);
        chk("t4_err", 32'(err), 32'b001);
        send(1'b1, 16'h0005);
        chk("t4_result", 32'(res_data), 32'h0014);

        // 5: illegal opcode then XOR
        do_reset();
        send(1'b0, 16'h00A5);
        send(1'b0, 16'h0013);
        send(1'b1, 16'h0006);
        chk("t5_err", 32'(err), 32'b100);
        chk("t5_depth", 32'(depth), 32'd2);
        send(1'b1, 16'h0004);
        send(1'b1, 16'h0005);
        chk("t5_result", 32'(res_data), 32'h00B6);

        // 6: reset during CAP_A of an ADD
        do_reset();
        send(1'b0, 16'h0021);
        send(1'b0, 16'h0022);
        @(negedge clk);
        tok_valid = 1'b1;
        tok_is_op = 1'b1;
        tok_data  = 16'h0000;
        @(posedge clk);
        #1 tok_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_outputs", {12'd0, tok_ready, stk_push, stk_pop, res_valid, depth, err, 9'd0},
            32'd0);
        chk("t6_res_data", 32'(res_data), 32'd0);
        chk("t6_value_in", 32'(stk_value_in), 32'd0);
        reset = 1'b0;
        mq.delete();
        err_m = 3'b000;
        res_m = 16'h0000;
        send(1'b0, 16'h0012);
        send(1'b1, 16'h0005);
        chk("t6_result", 32'(res_data), 32'h0012);

        // Randomized token stream against the reference model
        do_reset();
        for (int i = 0; i < 200; i++) begin
            if (i % 40 == 39) do_reset();
            d = 16'($urandom);
            if ($urandom_range(0, 99) < 45) begin
                sel = $urandom_range(0, 15);
                if (sel < 10) op = 3'(sel % 5);
                else if (sel < 14) op = 3'd5;
                else op = 3'(6 + sel % 2);
                d[2:0] = op;
                send(1'b1, d);
            end else begin
                send(1'b0, d);
            end
        end

        chk("push_pop_overlap", 32'(overlap_cnt), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
